// File: rtl/seg7_pkg.sv
// Shared definitions for the HEX display blocks: active-low segment patterns
// ({g,f,e,d,c,b,a}), controller state type and the 2-bit digit decoder.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        IDLE,
        LOCKOUT
    } ctrl_state_t;

    // Only the four digit patterns are reachable; the downstream encoder relies on it.
    function automatic logic [6:0] seg7_decode(input logic [1:0] digit);
        logic [6:0] seg;
        case (digit)
            2'd0:    seg = SEG_0;
            2'd1:    seg = SEG_1;
            2'd2:    seg = SEG_2;
            default: seg = SEG_3;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchronizer plus previous-value flop for one active-low pushbutton;
// press pulses for one cycle on each synchronized falling edge.
module key_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic press
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // All three flops reset to the released level so reset never fakes a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign press = !sync2_q && prev_q;

endmodule

// File: rtl/seg7_key_counter.sv
// Button-driven mod-4 counter with lockout debouncing, driving one active-low
// HEX digit (0-3) and exporting the binary count plus a one-cycle wrap pulse.
module seg7_key_counter
    import seg7_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       up_key,
    input  logic       down_key,
    output logic [6:0] hex,
    output logic [1:0] val,
    output logic       wrap
);

    localparam int LW = $clog2(DEBOUNCE_CYCLES + 1);

    ctrl_state_t   state_q;
    logic [LW-1:0] lock_cnt_q;
    logic [1:0]    count_q;
    logic          wrap_q;
    logic          up_press;
    logic          down_press;

    key_sync_edge u_up_sync (
        .clk   (clk),
        .reset (reset),
        .key   (up_key),
        .press (up_press)
    );

    key_sync_edge u_down_sync (
        .clk   (clk),
        .reset (reset),
        .key   (down_key),
        .press (down_press)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            lock_cnt_q <= '0;
            count_q    <= 2'd0;
            wrap_q     <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Simultaneous up+down is ambiguous, so it is dropped without a lockout.
                    if (up_press ^ down_press) begin
                        count_q    <= up_press ? count_q + 2'd1 : count_q - 2'd1;
                        wrap_q     <= up_press ? (count_q == 2'd3) : (count_q == 2'd0);
                        lock_cnt_q <= LW'(DEBOUNCE_CYCLES);
                        state_q    <= LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    lock_cnt_q <= lock_cnt_q - 1'b1;
                    if (lock_cnt_q == LW'(1)) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign hex  = seg7_decode(count_q);
    assign val  = count_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_seg7_key_counter.sv
// Bench for seg7_key_counter: directed scenarios plus random key activity, every
// cycle compared against an edge-timestamp model of presses and lockout windows.
module tb_seg7_key_counter;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       up_key = 1'b1;
    logic       down_key = 1'b1;
    logic [6:0] hex;
    logic [1:0] val;
    logic       wrap;

    seg7_key_counter #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .reset    (reset),
        .up_key   (up_key),
        .down_key (down_key),
        .hex      (hex),
        .val      (val),
        .wrap     (wrap)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: key level sampled at each post-reset edge n (indices 0..2 are the
    // released level seen before the first edge). A press is detected for edge n
    // when the key was high at edge n-3 and low at edge n-2; it is applied at edge
    // n only if no step was accepted in the previous D edges.
    bit hu[8192];
    bit hd[8192];
    int n;
    int last_acc;
    int m_val;
    bit m_wrap;
    int wrap_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] exp_hex(input int v);
        case (v)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            default: return 7'b0110000;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hu[i] = 1'b1;
            hd[i] = 1'b1;
        end
        n         = 2;
        last_acc  = -100;
        m_val     = 0;
        m_wrap    = 1'b0;
    endtask

    // Called between a negedge and the following posedge: reset must act at once.
    task automatic do_reset();
        #1;
        reset    = 1'b1;
        up_key   = 1'b1;
        down_key = 1'b1;
        #1;
        check("rst_val", 32'(val), 32'd0);
        check("rst_hex", 32'(hex), 32'h40);
        check("rst_wrap", 32'(wrap), 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic tick();
        bit du;
        bit dd;
        @(posedge clk);
        n++;
        hu[n]  = up_key;
        hd[n]  = down_key;
        du     = !hu[n-2] && hu[n-3];
        dd     = !hd[n-2] && hd[n-3];
        m_wrap = 1'b0;
        if ((du != dd) && (n >= last_acc + D + 1)) begin
            if (du) begin
                m_wrap = (m_val == 3);
                m_val  = (m_val + 1) % 4;
            end else begin
                m_wrap = (m_val == 0);
                m_val  = (m_val + 3) % 4;
            end
            last_acc = n;
            $display("step: edge %0d %s -> val=%0d wrap=%0d", n, du ? "up" : "down", m_val, m_wrap);
        end
        @(negedge clk);
        if (wrap === 1'b1) wrap_seen++;
        check("val", 32'(val), 32'(m_val));
        check("hex", 32'(hex), 32'(exp_hex(m_val)));
        check("wrap", 32'(wrap), 32'(m_wrap));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Held up press: one step at the third edge, nothing more while held or on release.
        up_key = 1'b0;
        repeat (3) tick();
        check("held_e3_val", 32'(val), 32'd1);
        check("held_e3_hex", 32'(hex), 32'h79);
        repeat (17) tick();
        up_key = 1'b1;
        repeat (10) tick();
        check("held_end_val", 32'(val), 32'd1);

        // Four spaced up presses from zero: 1,2,3,0 with a single wrap cycle.
        do_reset();
        wrap_seen = 0;
        for (int i = 0; i < 4; i++) begin
            up_key = 1'b0;
            tick();
            up_key = 1'b1;
            repeat (9) tick();
        end
        check("four_up_val", 32'(val), 32'd0);
        check("four_up_wraps", 32'(wrap_seen), 32'd1);

        // Down from reset wraps to 3; reset is then hit inside the wrap/lockout cycle.
        do_reset();
        down_key = 1'b0;
        repeat (3) tick();
        check("down_val", 32'(val), 32'd3);
        check("down_hex", 32'(hex), 32'h30);
        check("down_wrap", 32'(wrap), 32'd1);
        do_reset();

        // Bounce inside the lockout, then a clean press 8 cycles after the first step.
        for (int i = 1; i <= 20; i++) begin
            up_key = !((i == 1) || (i >= 3 && i <= 6) || (i == 11));
            tick();
        end
        up_key = 1'b1;
        check("bounce_val", 32'(val), 32'd2);

        // Simultaneous presses are discarded; a following up press is accepted.
        do_reset();
        wrap_seen = 0;
        up_key   = 1'b0;
        down_key = 1'b0;
        tick();
        up_key   = 1'b1;
        down_key = 1'b1;
        repeat (3) tick();
        check("simul_val", 32'(val), 32'd0);
        check("simul_wraps", 32'(wrap_seen), 32'd0);
        up_key = 1'b0;
        tick();
        up_key = 1'b1;
        repeat (4) tick();
        check("after_simul_val", 32'(val), 32'd1);

        // Random key activity with occasional resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 3) == 0) up_key = ~up_key;
            if ($urandom_range(0, 3) == 0) down_key = ~down_key;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
